// File: rtl/axi2ahb_rdata.sv
// axi2ahb_rdata: buffers AHB read beats of one AXI burst and replays them on the AXI R channel.
// Define AXI2AHB_RDATA_ERR_STICKY_EN so that an ERROR beat turns the rest of its burst into SLVERR.
module axi2ahb_rdata #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [AXI_DATA_WIDTH-1:0] HRDATA,
  input  logic                      HREADY,
  input  logic                      HRESP,
  output logic [AXI_DATA_WIDTH-1:0] RDATA,
  output logic [AXI_ID_WIDTH-1:0]   RID,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id_i,
  input  logic [7:0]                cmd_len_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      ctrl_rdata_phase_i,
  output logic                      ctrl_rdata_ready_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = AXI_ID_WIDTH + 3 + AXI_DATA_WIDTH;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  r_state;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [7:0]              r_len;
  logic [7:0]              r_cnt;
  logic [EW-1:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [AW:0]             r_count;

  logic                    w_cap;
  logic                    w_last;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_err;
  logic [1:0]              w_rresp;
  logic [AW:0]             w_free;
  logic [EW-1:0]           w_head;

  assign w_cap   = (r_state == BURST) && ctrl_rdata_phase_i && HREADY;
  assign w_last  = (r_cnt == r_len);
  assign w_full  = (r_count == DEPTH_C);
  assign w_push  = w_cap && !w_full;
  assign w_pop   = (r_count != '0) && RREADY;
  assign w_free  = DEPTH_C - r_count;
  assign w_rresp = w_err ? 2'b10 : 2'b00;

`ifdef AXI2AHB_RDATA_ERR_STICKY_EN
  logic r_err;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_err <= 1'b0;
    end else if (cmd_valid_i && cmd_ready_o) begin
      r_err <= 1'b0;
    end else if (w_cap && HRESP) begin
      r_err <= 1'b1;
    end
  end

  assign w_err = HRESP || r_err;
`else
  assign w_err = HRESP;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_state <= BURST;
            r_id    <= cmd_id_i;
            r_len   <= cmd_len_i;
            r_cnt   <= '0;
          end
        end
        BURST: begin
          if (w_cap) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

  // Storage needs no reset: the occupancy counter alone defines which entries are live.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_id, w_rresp, w_last, HRDATA};
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is masked while empty so the R payload reads as zero out of reset.
  assign w_head = r_mem[r_rptr];
  assign RVALID = (r_count != '0);
  assign {RID, RRESP, RLAST, RDATA} = RVALID ? w_head : '0;

  assign cmd_ready_o        = (r_state == IDLE);
  assign ctrl_rdata_ready_o = (r_state == BURST) && (w_free >= (AW + 1)'(2));
endmodule

// File: tb/tb_axi2ahb_rdata.sv
// Scoreboard bench for axi2ahb_rdata: randomized AHB beats, expected R beats queued at issue time.
`timescale 1ns/1ps
module tb_axi2ahb_rdata;
  localparam int IDW   = 1;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef AXI2AHB_RDATA_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic           ACLK = 1'b0;
  logic           ARESET = 1'b1;
  logic [DW-1:0]  HRDATA = '0;
  logic           HREADY = 1'b1;
  logic           HRESP = 1'b0;
  logic [DW-1:0]  RDATA;
  logic [IDW-1:0] RID;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY = 1'b0;
  logic [IDW-1:0] cmd_id_i = '0;
  logic [7:0]     cmd_len_i = '0;
  logic           cmd_valid_i = 1'b0;
  logic           cmd_ready_o;
  logic           ctrl_rdata_phase_i = 1'b0;
  logic           ctrl_rdata_ready_o;

  always #5 ACLK = ~ACLK;

  axi2ahb_rdata #(
    .AXI_ID_WIDTH  (IDW),
    .AXI_DATA_WIDTH(DW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .ACLK              (ACLK),
    .ARESET            (ARESET),
    .HRDATA            (HRDATA),
    .HREADY            (HREADY),
    .HRESP             (HRESP),
    .RDATA             (RDATA),
    .RID               (RID),
    .RRESP             (RRESP),
    .RLAST             (RLAST),
    .RVALID            (RVALID),
    .RREADY            (RREADY),
    .cmd_id_i          (cmd_id_i),
    .cmd_len_i         (cmd_len_i),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_ready_o       (cmd_ready_o),
    .ctrl_rdata_phase_i(ctrl_rdata_phase_i),
    .ctrl_rdata_ready_o(ctrl_rdata_ready_o)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
    logic           last;
    logic [DW-1:0]  data;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    rr_rand = 1'b0;
  bit    rr_fixed = 1'b1;
  int    caps;
  int    first_block;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // R-channel consumer
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      RREADY = rr_rand ? ($urandom_range(0, 1) == 1) : rr_fixed;
    end
  end

  // Monitor: pops the scoreboard on every R handshake and checks payload stability under backpressure
  initial begin
    beat_t got;
    beat_t hold;
    beat_t e;
    bit    hold_v;
    hold_v = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        hold_v = 1'b0;
        continue;
      end
      got = {RID, RRESP, RLAST, RDATA};
      if (hold_v && RVALID) chk("r_stable", longint'(got), longint'(hold));
      if (RVALID && RREADY) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL r_unexpected: got id=%0h resp=%0h last=%0b data=0x%0h, expected no beat",
                   RID, RRESP, RLAST, RDATA);
        end else begin
          e = exp_q.pop_front();
          chk("r_beat", longint'(got), longint'(e));
        end
        hold_v = 1'b0;
      end else begin
        hold_v = RVALID;
        hold   = got;
      end
    end
  end

  task automatic send_cmd(input logic [IDW-1:0] id, input logic [7:0] len);
    int t;
    t = 0;
    @(posedge ACLK);
    #1;
    cmd_valid_i = 1'b1;
    cmd_id_i    = id;
    cmd_len_i   = len;
    while (!cmd_ready_o && t < 100) begin
      @(posedge ACLK);
      #1;
      t++;
    end
    if (!cmd_ready_o) fail_now("cmd_accept");
    @(posedge ACLK);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  // Acts as the AHB controller: issues a beat only when the block grants it, with optional wait states.
  task automatic run_beats(input logic [IDW-1:0] id, input int len, input int base, input int err_beat,
                           input bit rand_err, input int waits, input int stop_after, input bit release_stall);
    bit            seen_err;
    bit            e;
    int            stall;
    int            w;
    logic [DW-1:0] d;
    beat_t         eb;
    seen_err    = 1'b0;
    stall       = 0;
    caps        = 0;
    first_block = -1;
    for (int b = 0; b <= len && b < stop_after; b++) begin
      d = (base >= 0) ? DW'(base + b) : DW'($urandom);
      e = rand_err ? ($urandom_range(0, 7) == 0) : (b == err_beat);
      w = (waits >= 0) ? waits : int'($urandom_range(0, 2));
      while (!ctrl_rdata_ready_o) begin
        if (first_block < 0) first_block = caps;
        ctrl_rdata_phase_i = 1'b0;
        HREADY = 1'b1;
        @(posedge ACLK);
        #1;
        stall++;
        if (release_stall && stall == 10) rr_fixed = 1'b1;
        if (stall > 500) begin
          fail_now("ctrl_ready_wait");
          ctrl_rdata_phase_i = 1'b0;
          return;
        end
      end
      ctrl_rdata_phase_i = 1'b1;
      HRDATA = d;
      for (int k = 0; k < w; k++) begin
        HREADY = 1'b0;
        HRESP  = 1'b0;
        @(posedge ACLK);
        #1;
      end
      HREADY  = 1'b1;
      HRESP   = e;
      eb.id   = id;
      eb.resp = (e || (STICKY && seen_err)) ? 2'b10 : 2'b00;
      eb.last = (b == len);
      eb.data = d;
      seen_err = seen_err || e;
      exp_q.push_back(eb);
      @(posedge ACLK);
      #1;
      caps++;
      chk("rvalid_after_capture", longint'(RVALID), 1);
    end
    ctrl_rdata_phase_i = 1'b0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge ACLK);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain");
      exp_q.delete();
    end
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_rvalid", longint'(RVALID), 0);
    chk("rst_rdata", longint'(RDATA), 0);
    chk("rst_rid", longint'(RID), 0);
    chk("rst_rresp", longint'(RRESP), 0);
    chk("rst_rlast", longint'(RLAST), 0);
    chk("rst_cmd_ready", longint'(cmd_ready_o), 1);
    chk("rst_ctrl_ready", longint'(ctrl_rdata_ready_o), 0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    // Basic in-order burst
    rr_fixed = 1'b1;
    send_cmd(1'b1, 8'd3);
    chk("rvalid_before_first", longint'(RVALID), 0);
    run_beats(1'b1, 3, 'hA0, -1, 1'b0, 0, 99, 1'b0);
    wait_drain();

    // Backpressure fills the buffer; controller grant drops with one slot in reserve
    rr_fixed = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    send_cmd(1'b0, 8'd7);
    run_beats(1'b0, 7, 'h100, -1, 1'b0, 0, 99, 1'b1);
    chk("ready_drop_caps", first_block, 3);
    wait_drain();

    // Error on beat 1
    send_cmd(1'b1, 8'd3);
    run_beats(1'b1, 3, 'h200, 1, 1'b0, 0, 99, 1'b0);
    wait_drain();

    // Wait states, then data phase while idle
    send_cmd(1'b1, 8'd0);
    run_beats(1'b1, 0, 'h55, -1, 1'b0, 2, 99, 1'b0);
    wait_drain();
    ctrl_rdata_phase_i = 1'b1;
    HREADY = 1'b1;
    HRESP  = 1'b1;
    repeat (4) @(posedge ACLK);
    #1;
    ctrl_rdata_phase_i = 1'b0;
    HRESP = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("idle_phase_rvalid", longint'(RVALID), 0);
    chk("idle_phase_cmd_ready", longint'(cmd_ready_o), 1);

    // Reset mid-burst
    rr_fixed = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    send_cmd(1'b0, 8'd3);
    run_beats(1'b0, 3, 'hB0, -1, 1'b0, 0, 2, 1'b0);
    #2;
    ARESET = 1'b1;
    #1;
    chk("midrst_rvalid", longint'(RVALID), 0);
    chk("midrst_cmd_ready", longint'(cmd_ready_o), 1);
    chk("midrst_ctrl_ready", longint'(ctrl_rdata_ready_o), 0);
    exp_q.delete();
    @(posedge ACLK);
    #1;
    ARESET   = 1'b0;
    rr_fixed = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("post_rst_rvalid", longint'(RVALID), 0);
    send_cmd(1'b1, 8'd0);
    run_beats(1'b1, 0, 'hC0, -1, 1'b0, 0, 99, 1'b0);
    wait_drain();

    // Randomized bursts with random backpressure, wait states and errors
    rr_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      logic [IDW-1:0] rid;
      int             rlen;
      rid  = IDW'($urandom_range(0, 1));
      rlen = int'($urandom_range(0, 15));
      send_cmd(rid, 8'(rlen));
      run_beats(rid, rlen, -1, -1, 1'b1, -1, 999, 1'b0);
    end
    wait_drain();
    chk("queue_empty_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
